// File: rtl/fetch_req_ctrl.sv
// fetch_req_ctrl: front-end fetch request sequencer.
// Issues one aligned fetch block request at a time to the I-cache, forwards
// the matching response to the instruction queue and picks the next fetch
// address from flush / replay / branch prediction / sequential order.
// Optional feature: define FETCH_REQ_CTRL_REPLAY_CNT_EN to get a saturating
// replay event counter on replay_cnt_o (otherwise it reads constant 0).
module fetch_req_ctrl #(
   parameter int unsigned FETCH_BYTES = 8,
   parameter logic [63:0] BOOT_ADDR   = 64'h0000_0000_8000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic [63:0] flush_addr_i,
   input  logic        halt_i,
   input  logic        iq_ready_i,
   output logic        icache_req_o,
   output logic [63:0] icache_addr_o,
   input  logic        icache_gnt_i,
   input  logic        icache_rsp_valid_i,
   output logic        icache_kill_o,
   output logic        rsp_valid_o,
   input  logic        bp_valid_i,
   input  logic [63:0] bp_addr_i,
   input  logic        replay_i,
   input  logic [63:0] replay_addr_i,
   output logic [31:0] replay_cnt_o
);

   localparam logic [63:0] BLK_BYTES  = 64'(FETCH_BYTES);
   localparam logic [63:0] ALIGN_MASK = ~(BLK_BYTES - 64'd1);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [63:0] faddr_q, faddr_d;
   logic [63:0] faddr_al;
   logic        req_int;
   logic        rsp_fwd;
   logic        kill_int;

   // Request/response qualifiers derived from the current state and inputs.
   always_comb begin
      faddr_al = faddr_q & ALIGN_MASK;
      req_int  = (state_q == S_REQ) & ~flush_i & ~halt_i & iq_ready_i;
      rsp_fwd  = (state_q == S_WAIT) & icache_rsp_valid_i & ~flush_i;
      kill_int = (state_q == S_WAIT) & flush_i & ~icache_rsp_valid_i;
   end

   // Outputs are forced to their reset values for as long as reset is held,
   // since the state register only updates at the next edge.
   assign icache_req_o  = req_int & ~rst_i;
   assign rsp_valid_o   = rsp_fwd & ~rst_i;
   assign icache_kill_o = kill_int & ~rst_i;
   assign icache_addr_o = rst_i ? (BOOT_ADDR & ALIGN_MASK) : faddr_al;

   // Next-state and next fetch address selection.
   always_comb begin
      state_d = state_q;
      faddr_d = faddr_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_REQ;
            if (flush_i) faddr_d = flush_addr_i;
         end
         S_REQ: begin
            if (flush_i)                      faddr_d = flush_addr_i;
            else if (req_int & icache_gnt_i)  state_d = S_WAIT;
         end
         S_WAIT: begin
            if (icache_rsp_valid_i) begin
               // replay/bp only count when the response is actually forwarded,
               // which the flush-first priority already guarantees here.
               state_d = S_REQ;
               if (flush_i)         faddr_d = flush_addr_i;
               else if (replay_i)   faddr_d = replay_addr_i;
               else if (bp_valid_i) faddr_d = bp_addr_i;
               else                 faddr_d = faddr_al + BLK_BYTES;
            end else if (flush_i) begin
               faddr_d = flush_addr_i;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Waiting out the killed request; its response is dropped.
            if (flush_i)            faddr_d = flush_addr_i;
            if (icache_rsp_valid_i) state_d = S_REQ;
         end
         default: state_d = S_BOOT;
      endcase
   end

   // State and fetch address registers, reset has top priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_BOOT;
         faddr_q <= BOOT_ADDR;
      end else begin
         state_q <= state_d;
         faddr_q <= faddr_d;
      end
   end

`ifdef FETCH_REQ_CTRL_REPLAY_CNT_EN
   logic [31:0] replay_cnt_q;

   // Saturating count of forwarded responses that requested a replay.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         replay_cnt_q <= '0;
      else if (rsp_fwd & replay_i & (replay_cnt_q != 32'hFFFF_FFFF))
         replay_cnt_q <= replay_cnt_q + 32'd1;
   end

   assign replay_cnt_o = rst_i ? 32'd0 : replay_cnt_q;
`else
   assign replay_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Self-checking bench for fetch_req_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_req_ctrl;

   localparam logic [63:0] BOOT = 64'h0000_0000_8000_0000;
   localparam logic [63:0] FB   = 64'd8;
`ifdef FETCH_REQ_CTRL_REPLAY_CNT_EN
   localparam logic [31:0] CNT_INC = 32'd1;
`else
   localparam logic [31:0] CNT_INC = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1, flush = 1'b0, halt = 1'b0, iq_ready = 1'b0;
   logic        gnt = 1'b0, rsp_v = 1'b0, bp_v = 1'b0, replay = 1'b0;
   logic [63:0] flush_addr = '0, bp_addr = '0, replay_addr = '0;
   logic        req, kill, rsp_o;
   logic [63:0] addr;
   logic [31:0] cnt;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fetch_req_ctrl dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .flush_i            (flush),
      .flush_addr_i       (flush_addr),
      .halt_i             (halt),
      .iq_ready_i         (iq_ready),
      .icache_req_o       (req),
      .icache_addr_o      (addr),
      .icache_gnt_i       (gnt),
      .icache_rsp_valid_i (rsp_v),
      .icache_kill_o      (kill),
      .rsp_valid_o        (rsp_o),
      .bp_valid_i         (bp_v),
      .bp_addr_i          (bp_addr),
      .replay_i           (replay),
      .replay_addr_i      (replay_addr),
      .replay_cnt_o       (cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // booting: first cycle after reset; busy: a grant is awaiting its response;
   // dropping: that response was abandoned by a flush.
   bit          m_booting = 0, m_busy = 0, m_dropping = 0;
   logic [63:0] m_faddr = '0;
   logic [31:0] m_cnt = '0;
   bit          n_booting = 0, n_busy = 0, n_dropping = 0;
   logic [63:0] n_faddr = '0;
   logic [31:0] n_cnt = '0;
   logic [63:0] e_addr;
   logic        e_req, e_rsp, e_kill;

   // Compare DUT outputs to the model mid-cycle and compute the next model state.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_req", req, 0);
         chk("rst_kill", kill, 0);
         chk("rst_rsp", rsp_o, 0);
         chk("rst_addr", addr, BOOT);
         chk("rst_cnt", cnt, 0);
         n_booting = 1; n_busy = 0; n_dropping = 0; n_faddr = BOOT; n_cnt = '0;
      end else begin
         e_addr = (m_faddr / FB) * FB;
         e_req  = !m_booting && !m_busy && !flush && !halt && iq_ready;
         e_rsp  = m_busy && !m_dropping && rsp_v && !flush;
         e_kill = m_busy && !m_dropping && flush && !rsp_v;
         chk("m_req", req, e_req);
         chk("m_addr", addr, e_addr);
         chk("m_rsp", rsp_o, e_rsp);
         chk("m_kill", kill, e_kill);
         chk("m_cnt", cnt, m_cnt);
         n_booting = 0; n_busy = m_busy; n_dropping = m_dropping;
         n_faddr = m_faddr; n_cnt = m_cnt;
         if (flush) n_faddr = flush_addr;
         if (m_busy && rsp_v) begin
            n_busy = 0; n_dropping = 0;
            if (e_rsp) n_faddr = replay ? replay_addr : bp_v ? bp_addr : e_addr + FB;
         end else if (m_busy && flush) begin
            n_dropping = 1;
         end else if (e_req && gnt) begin
            n_busy = 1;
         end
         if (e_rsp && replay && m_cnt != 32'hFFFF_FFFF) n_cnt = m_cnt + CNT_INC;
      end
   end

   always @(posedge clk) begin
      m_booting = n_booting; m_busy = n_busy; m_dropping = n_dropping;
      m_faddr = n_faddr; m_cnt = n_cnt;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One REQ -> WAIT -> WAIT -> response sequence with a 2-cycle memory.
   task automatic fetch_one(input string tag, input logic [63:0] exp_addr,
                            input logic bpv, input logic [63:0] ba,
                            input logic rpv, input logic [63:0] ra);
      rsp_v = 0; bp_v = 0; replay = 0;
      #1;
      chk({tag, "_req"}, req, 1);
      chk({tag, "_addr"}, addr, exp_addr);
      tick();
      tick();
      rsp_v = 1; bp_v = bpv; bp_addr = ba; replay = rpv; replay_addr = ra;
      #1;
      chk({tag, "_rsp"}, rsp_o, 1);
      tick();
      rsp_v = 0; bp_v = 0; replay = 0;
   endtask

   bit mem_pend = 0;
   int mem_lat = 0;

   initial begin
      // reset held with noisy inputs
      rst = 1; flush = 1; gnt = 1; rsp_v = 1; iq_ready = 1; replay = 1;
      flush_addr = 64'h1234;
      tick(); tick();
      #1;
      chk("reset_req", req, 0);
      chk("reset_addr", addr, BOOT);
      rst = 0; flush = 0; rsp_v = 0; replay = 0;
      #1;
      chk("boot_req", req, 0);
      chk("boot_addr", addr, 64'h8000_0000);
      tick();

      // sequential fetches, branch prediction, replay with priority over bp
      fetch_one("seq0", 64'h8000_0000, 0, 0, 0, 0);
      fetch_one("seq1", 64'h8000_0008, 0, 0, 0, 0);
      fetch_one("seq2", 64'h8000_0010, 1, 64'h8000_0100, 0, 0);
      fetch_one("bp",   64'h8000_0100, 1, 64'h9000_0000, 1, 64'h8000_0006);
      #1;
      chk("replay_cnt", cnt, CNT_INC);

      // flush while waiting: kill pulse, late response dropped
      #1;
      chk("rpl_addr", addr, 64'h8000_0000);
      chk("rpl_req", req, 1);
      tick();
      flush = 1; flush_addr = 64'h8000_2000;
      #1;
      chk("wflush_kill", kill, 1);
      chk("wflush_rsp", rsp_o, 0);
      tick();
      flush = 0;
      #1;
      chk("drain_kill", kill, 0);
      tick();
      rsp_v = 1;
      #1;
      chk("late_rsp", rsp_o, 0);
      tick();
      rsp_v = 0;
      #1;
      chk("post_flush_addr", addr, 64'h8000_2000);
      chk("post_flush_req", req, 1);

      // flush coincident with response and replay
      tick();
      rsp_v = 1; replay = 1; replay_addr = 64'h8000_0040;
      flush = 1; flush_addr = 64'h8000_3000;
      #1;
      chk("coflush_rsp", rsp_o, 0);
      chk("coflush_kill", kill, 0);
      tick();
      rsp_v = 0; replay = 0; flush = 0;
      #1;
      chk("coflush_addr", addr, 64'h8000_3000);
      chk("coflush_cnt", cnt, CNT_INC);

      // instruction queue back-pressure
      for (int i = 0; i < 5; i++) begin
         iq_ready = 0;
         #1;
         chk("bp_stall_req", req, 0);
         chk("bp_stall_addr", addr, 64'h8000_3000);
         tick();
      end
      iq_ready = 1;
      #1;
      chk("resume_req", req, 1);
      tick();

      // reset while waiting
      rst = 1; flush = 1; rsp_v = 1;
      #1;
      chk("wrst_req", req, 0);
      chk("wrst_kill", kill, 0);
      chk("wrst_rsp", rsp_o, 0);
      chk("wrst_addr", addr, BOOT);
      chk("wrst_cnt", cnt, 0);
      tick();
      rst = 0; flush = 0; rsp_v = 0;
      #1;
      chk("wrst_boot_req", req, 0);
      chk("wrst_boot_addr", addr, BOOT);
      tick();

      // randomized traffic against the model; memory answers each grant once
      for (int c = 0; c < 4000; c++) begin
         if (!m_busy) mem_pend = 0;
         else if (!mem_pend) begin
            mem_pend = 1;
            mem_lat  = $urandom_range(0, 3);
         end
         rsp_v = mem_pend && (mem_lat == 0);
         if (rsp_v) mem_pend = 0;
         else if (mem_pend) mem_lat--;
         rst         = ($urandom_range(0, 299) == 0);
         flush       = ($urandom_range(0, 9) == 0);
         halt        = ($urandom_range(0, 7) == 0);
         iq_ready    = ($urandom_range(0, 7) != 0);
         gnt         = $urandom_range(0, 1) != 0;
         bp_v        = ($urandom_range(0, 3) == 0);
         replay      = ($urandom_range(0, 5) == 0);
         bp_addr     = {$urandom, $urandom};
         replay_addr = {$urandom, $urandom};
         flush_addr  = {$urandom, $urandom};
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_req_ctrl.md
FETCH_REQ_CTRL -- requirements
Module: fetch_req_ctrl

Interface
REQ-001 Parameters SHALL be:
- FETCH_BYTES, default 8, fetch block size in bytes (power of two).
- BOOT_ADDR, default 64'h0000_0000_8000_0000, first fetch address after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- rst_i, in, 1, synchronous active-high reset.
- flush_i, in, 1, backend flush.
- flush_addr_i, in, 64, restart address for the flush.
- halt_i, in, 1, stop issuing new requests.
- iq_ready_i, in, 1, instruction queue can accept a fetch block.
- icache_req_o, out, 1, fetch request valid.
- icache_addr_o, out, 64, fetch address (aligned to FETCH_BYTES).
- icache_gnt_i, in, 1, request accepted.
- icache_rsp_valid_i, in, 1, response data valid (exactly one per grant).
- icache_kill_o, out, 1, abandon the outstanding request.
- rsp_valid_o, out, 1, response is forwarded to the instruction queue.
- bp_valid_i, in, 1, taken prediction in the current response.
- bp_addr_i, in, 64, predicted target.
- replay_i, in, 1, the instruction queue overflowed on this response.
- replay_addr_i, in, 64, address to refetch.
- replay_cnt_o, out, 32, replay event count.

Function
REQ-003 The block SHALL hold a 64-bit fetch address register (faddr) and an FSM with the states BOOT, REQ, WAIT, DRAIN.

REQ-004 BOOT SHALL last exactly one cycle, then go to REQ; icache_req_o is 0 in BOOT.

REQ-005 icache_req_o SHALL be: state==REQ & ~flush_i & ~halt_i & iq_ready_i.

REQ-006 icache_addr_o SHALL equal faddr with its low log2(FETCH_BYTES) bits cleared.

REQ-007 In REQ, when icache_req_o & icache_gnt_i, the FSM SHALL go to WAIT the next cycle, and the block SHALL hold at most one request outstanding.

REQ-008 In WAIT:
- rsp_valid_o SHALL be icache_rsp_valid_i & ~flush_i, combinationally.
- On icache_rsp_valid_i the FSM SHALL return to REQ.

REQ-009 When a response completes in WAIT, the next faddr SHALL be chosen by priority:
- flush_i -> flush_addr_i.
- replay_i -> replay_addr_i.
- bp_valid_i -> bp_addr_i.
- otherwise the aligned faddr + FETCH_BYTES, 64-bit wrap-around, no carry out.

REQ-010 replay_i and bp_valid_i SHALL be ignored unless rsp_valid_o=1 in the same cycle.

REQ-011 flush_i in WAIT without icache_rsp_valid_i SHALL:
- pulse icache_kill_o for one cycle;
- load faddr=flush_addr_i;
- go to DRAIN.

REQ-012 In DRAIN:
- rsp_valid_o SHALL be 0.
- On icache_rsp_valid_i the FSM SHALL go to REQ.
- A further flush_i SHALL reload faddr and stay in DRAIN (or go to REQ if the response arrives the same cycle), with no new kill pulse.

REQ-013 flush_i in REQ or BOOT SHALL load faddr=flush_addr_i and suppress a request that cycle. From BOOT the FSM still goes to REQ.

REQ-014 In REQ, faddr SHALL be stable while icache_req_o=1 and no grant has occurred.

REQ-015 halt_i or ~iq_ready_i SHALL NOT affect a response already outstanding.

Reset
REQ-016 When rst_i=1 at a clock edge, the block SHALL set:
- state=BOOT, faddr=BOOT_ADDR, replay_cnt=0.
- Any outstanding response is forgotten, with no kill pulse.

REQ-017 Output values while in reset and in the first cycle after reset SHALL be:
- icache_req_o=0, icache_kill_o=0, rsp_valid_o=0, replay_cnt_o=0.
- icache_addr_o=BOOT_ADDR.

REQ-018 Reset SHALL take priority over every other input.

Configuration
REQ-019 With macro FETCH_REQ_CTRL_REPLAY_CNT_EN defined:
- replay_cnt_o SHALL increment by 1 on each cycle with replay_i & rsp_valid_o.
- The count SHALL saturate at 32'hFFFF_FFFF.
- flush_i SHALL NOT clear the count.

REQ-020 Without the macro, replay_cnt_o SHALL be constant 0, no counter register is present, and all other behaviour is identical.

Verification
REQ-021 Reset then idle memory with gnt=1 and a response 2 cycles after each grant:
- First icache_addr_o = 0x8000_0000.
- Following requests at 0x8000_0008 and 0x8000_0010.

REQ-022 A response with bp_valid_i=1 and bp_addr_i=0x8000_0100:
- Next request at 0x8000_0100.
- The same response with replay_i=1 and replay_addr_i=0x8000_0006 instead gives a request at 0x8000_0000, rsp_valid_o=1, and replay_cnt_o +1 (macro on).

REQ-023 flush_i with flush_addr_i=0x8000_2000 while in WAIT:
- One-cycle icache_kill_o.
- A late response gives rsp_valid_o=0.
- Next request at 0x8000_2000.

REQ-024 flush_i in the same cycle as icache_rsp_valid_i and replay_i:
- rsp_valid_o=0, replay_cnt_o unchanged.
- Next address is flush_addr_i, no kill pulse.

REQ-025 iq_ready_i=0 for 5 cycles in REQ:
- icache_req_o=0 throughout, faddr unchanged.
- Request resumes the cycle iq_ready_i=1.
- rst_i=1 while in WAIT returns the block to BOOT and outputs to their reset values.
